// File: rtl/adapter_pkg.sv
// adapter_pkg: FSM state encoding and defaults shared by both ends of the credit link
package adapter_pkg;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    READ       = 3'd2,
    WRITE_RESP = 3'd3,
    READ_RESP  = 3'd4
  } state_t;
  localparam int DEPTH_DEF = 16;
  localparam int CRD_W_DEF = 7;
  localparam int LEN_W_DEF = 8;
  localparam int DATA_W_DEF = 64;
endpackage

// File: rtl/adapter_resp_if.sv
// adapter_resp_if: link, memory and status signals of the responder adapter; ADAPTER_RESP_STATS_EN adds beat counters
interface adapter_resp_if #(parameter int DATA_W = 64, parameter int LEN_W = 8);
  logic              wr_req, rd_req, cmd_valid, cmd_last, cmd_ready, crd;
  logic [LEN_W-1:0]  rd_len;
  logic [DATA_W-1:0] cmd_data, mem_data, mem_rd_data, rsp_data;
  logic              mem_valid, mem_ready, mem_rd_valid, mem_rd_ready, rsp_valid;
  logic              rd_crd, wr_resp, rd_resp, err;
  logic [2:0]        state;
`ifdef ADAPTER_RESP_STATS_EN
  logic [15:0]       wr_beats, rd_beats;
`endif
  modport master (
`ifdef ADAPTER_RESP_STATS_EN
    input wr_beats, rd_beats,
`endif
    output wr_req, rd_req, rd_len, cmd_valid, cmd_data, cmd_last, mem_ready,
    output mem_rd_valid, mem_rd_data, rd_crd,
    input cmd_ready, crd, mem_valid, mem_data, mem_rd_ready, rsp_valid, rsp_data,
    input wr_resp, rd_resp, err, state
  );
  modport slave (
`ifdef ADAPTER_RESP_STATS_EN
    output wr_beats, rd_beats,
`endif
    input wr_req, rd_req, rd_len, cmd_valid, cmd_data, cmd_last, mem_ready,
    input mem_rd_valid, mem_rd_data, rd_crd,
    output cmd_ready, crd, mem_valid, mem_data, mem_rd_ready, rsp_valid, rsp_data,
    output wr_resp, rd_resp, err, state
  );
endinterface

// File: rtl/adapter_resp_fifo.sv
// adapter_resp_fifo: sync write buffer, wrap-bit pointers; push while full succeeds only alongside a pop
module adapter_resp_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_push);
      rp <= rp + (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/adapter_resp_core.sv
// adapter_resp_core: responder end of the credit link; buffers writes, credit-gates reads (ADAPTER_RESP_STATS_EN adds beat counters)
module adapter_resp_core
  import adapter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CRD_W  = CRD_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input logic clk,
  input logic rst,
  adapter_resp_if.slave bus
);
  state_t state;
  logic last_seen, full, empty, push, pop, beat, crd_q, err_q;
  logic [LEN_W-1:0] beats_left;
  logic [CRD_W-1:0] rd_crd_cnt;
  assign push = state == WRITE && bus.cmd_valid && !full;
  assign pop = !empty && bus.mem_ready;
  assign beat = state == READ && bus.mem_rd_valid && rd_crd_cnt != '0;
  adapter_resp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(bus.cmd_data), .pop(pop),
    .dout(bus.mem_data), .full(full), .empty(empty)
  );
  assign bus.cmd_ready = state == WRITE && !full;
  assign bus.mem_valid = !empty;
  assign bus.mem_rd_ready = beat;
  assign bus.rsp_valid = beat;
  assign bus.rsp_data = bus.mem_rd_data;
  assign bus.wr_resp = state == WRITE_RESP;
  assign bus.rd_resp = state == READ_RESP;
  assign bus.crd = crd_q;
  assign bus.err = err_q;
  assign bus.state = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_seen <= 1'b0;
      beats_left <= '0;
      rd_crd_cnt <= '0;
      crd_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      crd_q <= pop;
      if (state == WRITE && bus.cmd_valid && full) err_q <= 1'b1;
      // a credit arriving with a sent beat nets to zero, including at saturation
      if (state == IDLE) rd_crd_cnt <= '0;
      else if (bus.rd_crd && !beat && rd_crd_cnt != '1) rd_crd_cnt <= rd_crd_cnt + 1'b1;
      else if (beat && !bus.rd_crd) rd_crd_cnt <= rd_crd_cnt - 1'b1;
      if (push && bus.cmd_last) last_seen <= 1'b1;
      if (beat) beats_left <= beats_left - 1'b1;
      case (state)
        IDLE: begin
          last_seen <= 1'b0;
          if (bus.rd_req) begin
            state <= READ;
            beats_left <= bus.rd_len == '0 ? LEN_W'(1) : bus.rd_len;
          end else if (bus.wr_req) state <= WRITE;
        end
        WRITE: if (last_seen && empty) state <= WRITE_RESP;
        READ: if (beat && beats_left == LEN_W'(1)) state <= READ_RESP;
        WRITE_RESP, READ_RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ADAPTER_RESP_STATS_EN
  logic [15:0] wr_beats_q, rd_beats_q;
  assign bus.wr_beats = wr_beats_q;
  assign bus.rd_beats = rd_beats_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_beats_q <= '0;
      rd_beats_q <= '0;
    end else begin
      if (push && wr_beats_q != 16'hFFFF) wr_beats_q <= wr_beats_q + 1'b1;
      if (beat && rd_beats_q != 16'hFFFF) rd_beats_q <= rd_beats_q + 1'b1;
    end
  end
`endif
endmodule
